// File: rtl/trig_ctrl_pkg.sv
// trig_ctrl_pkg: shared types and constants for the trigger controller.
//   state_e      - run-sequencer states
//   CMD_*        - channel command field encoding for wCMD
//   N_CH_DEF / DEPTH_W_DEF - default channel count and sample-counter width
//   is_run()     - true for the states in which capture is active
package trig_ctrl_pkg;

  localparam int N_CH_DEF    = 8;
  localparam int DEPTH_W_DEF = 10;

  // Channel command: bit3 enables the channel, bits1:0 select the match kind.
  localparam logic [3:0] CMD_EN   = 4'b1000;
  localparam logic [1:0] CMD_LOW  = 2'b00;
  localparam logic [1:0] CMD_HIGH = 2'b11;
  localparam logic [1:0] CMD_POS  = 2'b01;
  localparam logic [1:0] CMD_NEG  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic is_run(state_e s);
    return (s == ST_PRE) || (s == ST_WAIT) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/trig_cnt.sv
// trig_cnt: loadable down-counter with a zero flag, shared by the PRE and
// POST phases of the trigger controller.
//   CLK, RSTn - clock, async active-low reset
//   ld_i      - load val_i (has priority over dec_i)
//   dec_i     - decrement by one (saturates at zero)
//   val_i     - load value
//   zero_o    - counter is zero
module trig_cnt #(
  parameter int W = 10
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         ld_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i)                     cnt_d = val_i;
    else if (dec_i && !zero_o)    cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/trig_ctrl.sv
// trig_ctrl: trigger/capture sequencer for a bank of trig channels.
//   Config side : cfg_wr/cfg_addr/cfg_data -> one-cycle wEN pulse + wCMD,
//                 cfg_clr -> one-cycle SetInit pulse (only in IDLE/DONE).
//   Run side    : arm starts IDLE->PRE->WAIT->POST->DONE; abort returns to IDLE.
//                 cap_en/cap_addr drive sample-memory writes, trig_addr marks
//                 the sample at which all ResTri bits matched.
//   Status      : EN (channels enabled), triggered, busy, done.
// All outputs come straight from flops; run-status flops are loaded from the
// next state so they line up with the state register.
module trig_ctrl
  import trig_ctrl_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int DEPTH_W = DEPTH_W_DEF
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               cfg_wr,
  input  logic [7:0]         cfg_addr,
  input  logic [3:0]         cfg_data,
  input  logic               cfg_clr,
  input  logic               arm,
  input  logic               abort,
  input  logic [DEPTH_W-1:0] pre_cnt,
  input  logic [DEPTH_W-1:0] post_cnt,
  input  logic [N_CH-1:0]    ResTri,
  output logic [3:0]         wCMD,
  output logic [N_CH-1:0]    wEN,
  output logic               SetInit,
  output logic               EN,
  output logic               cap_en,
  output logic [DEPTH_W-1:0] cap_addr,
  output logic [DEPTH_W-1:0] trig_addr,
  output logic               triggered,
  output logic               busy,
  output logic               done
);

  localparam logic [DEPTH_W-1:0] ONE = DEPTH_W'(1);

  state_e             state_q, state_d;
  logic               hit_q;
  logic [DEPTH_W-1:0] post_q;
  logic [3:0]         wcmd_q;
  logic [N_CH-1:0]    wen_q, wen_d;
  logic               setinit_q, en_q, cap_en_q, busy_q, done_q, trig_q;
  logic [DEPTH_W-1:0] cap_addr_q, trig_addr_q;

  logic               cfg_ok, do_arm, do_abort, take_hit;
  logic               cnt_ld, cnt_dec, cnt_zero;
  logic [DEPTH_W-1:0] cnt_val;

  assign cfg_ok = (state_q == ST_IDLE) || (state_q == ST_DONE);

  // Channel write decode: out-of-range addresses match no lane and are dropped.
  for (genvar g = 0; g < N_CH; g++) begin : g_wen
    assign wen_d[g] = cfg_ok & cfg_wr & (cfg_addr == 8'(g));
  end

  // The shared counter holds pre_cnt-1 during PRE and post_cnt-1 during POST,
  // so a phase ends on the cycle the counter reads zero.
  trig_cnt #(.W(DEPTH_W)) u_cnt (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .ld_i   (cnt_ld),
    .dec_i  (cnt_dec),
    .val_i  (cnt_val),
    .zero_o (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    do_arm   = 1'b0;
    do_abort = 1'b0;
    take_hit = 1'b0;
    cnt_ld   = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_IDLE: do_arm = arm;
      ST_DONE: begin
        if (abort) do_abort = 1'b1;
        else       do_arm   = arm;
      end
      ST_PRE: begin
        if (abort)         do_abort = 1'b1;
        else if (cnt_zero) state_d  = ST_WAIT;
        else               cnt_dec  = 1'b1;
      end
      ST_WAIT: begin
        if (abort) do_abort = 1'b1;
        else if (hit_q) begin
          take_hit = 1'b1;
          if (post_q == '0) state_d = ST_DONE;
          else begin
            state_d = ST_POST;
            cnt_ld  = 1'b1;
            cnt_val = post_q - ONE;
          end
        end
      end
      ST_POST: begin
        if (abort)         do_abort = 1'b1;
        else if (cnt_zero) state_d  = ST_DONE;
        else               cnt_dec  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (do_abort) state_d = ST_IDLE;
    if (do_arm) begin
      cnt_ld  = (pre_cnt != '0);
      cnt_val = pre_cnt - ONE;
      state_d = cnt_ld ? ST_PRE : ST_WAIT;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      hit_q       <= 1'b0;
      post_q      <= '0;
      wcmd_q      <= '0;
      wen_q       <= '0;
      setinit_q   <= 1'b0;
      en_q        <= 1'b0;
      cap_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      trig_q      <= 1'b0;
      cap_addr_q  <= '0;
      trig_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      hit_q     <= (state_q == ST_WAIT) & (&ResTri);
      wen_q     <= wen_d;
      if (|wen_d) wcmd_q <= cfg_data;
      // A simultaneous channel write takes precedence over the clear.
      setinit_q <= cfg_ok & cfg_clr & ~cfg_wr;

      cap_en_q  <= is_run(state_d);
      busy_q    <= is_run(state_d);
      en_q      <= (state_d == ST_WAIT) || (state_d == ST_POST);
      done_q    <= (state_d == ST_DONE);

      if (do_arm) begin
        cap_addr_q <= '0;
        post_q     <= post_cnt;
      end else if (cap_en_q) begin
        cap_addr_q <= cap_addr_q + ONE;
      end

      // hit_q lags the matching sample by one cycle, hence the -1.
      if (take_hit) begin
        trig_addr_q <= cap_addr_q - ONE;
        trig_q      <= 1'b1;
      end else if (do_arm || do_abort) begin
        trig_q      <= 1'b0;
      end
    end
  end

  assign wCMD      = wcmd_q;
  assign wEN       = wen_q;
  assign SetInit   = setinit_q;
  assign EN        = en_q;
  assign cap_en    = cap_en_q;
  assign cap_addr  = cap_addr_q;
  assign trig_addr = trig_addr_q;
  assign triggered = trig_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_trig_ctrl.sv
// tb_trig_ctrl: directed + randomized bench for trig_ctrl (N_CH=8, DEPTH_W=10).
// Expected run behaviour is derived from the run parameters: with pre P,
// post Q and the first all-ones ResTri sample at run cycle S (S>=P), the run
// lasts P + (S+2-P) + Q cycles, triggered shows from cycle S+2 and
// trig_addr = S mod 1024.
module tb_trig_ctrl;
  import trig_ctrl_pkg::*;

  localparam int NC = 8;
  localparam int DW = 10;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          cfg_wr, cfg_clr, arm, abort;
  logic [7:0]    cfg_addr;
  logic [3:0]    cfg_data;
  logic [DW-1:0] pre_cnt, post_cnt;
  logic [NC-1:0] ResTri;
  logic [3:0]    wCMD;
  logic [NC-1:0] wEN;
  logic          SetInit, EN, cap_en, triggered, busy, done;
  logic [DW-1:0] cap_addr, trig_addr;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] last_cmd;

  trig_ctrl #(.N_CH(NC), .DEPTH_W(DW)) dut (
    .CLK(CLK), .RSTn(RSTn), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_clr(cfg_clr), .arm(arm), .abort(abort),
    .pre_cnt(pre_cnt), .post_cnt(post_cnt), .ResTri(ResTri),
    .wCMD(wCMD), .wEN(wEN), .SetInit(SetInit), .EN(EN), .cap_en(cap_en),
    .cap_addr(cap_addr), .trig_addr(trig_addr), .triggered(triggered),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC-1:0] nonff();
    logic [NC-1:0] v;
    v = NC'($urandom);
    v[$urandom_range(0, NC-1)] = 1'b0;
    return v;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_wEN"},       32'(wEN),       32'(0));
    chk({tag, "_SetInit"},   32'(SetInit),   32'(0));
    chk({tag, "_EN"},        32'(EN),        32'(0));
    chk({tag, "_cap_en"},    32'(cap_en),    32'(0));
    chk({tag, "_triggered"}, 32'(triggered), 32'(0));
    chk({tag, "_done"},      32'(done),      32'(0));
    chk({tag, "_busy"},      32'(busy),      32'(0));
    chk({tag, "_wCMD"},      32'(wCMD),      32'(0));
    chk({tag, "_cap_addr"},  32'(cap_addr),  32'(0));
    chk({tag, "_trig_addr"}, 32'(trig_addr), 32'(0));
  endtask

  // Full run from IDLE/DONE with first all-ones ResTri sample at run cycle s.
  task automatic do_run(input int p, input int q, input int s);
    int total, ca;
    total = s + 2 + q;
    pre_cnt = DW'(p); post_cnt = DW'(q); arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k <= total + 1; k++) begin
      ca = ((k < total) ? k : total) % (1 << DW);
      chk("run_cap_en",    32'(cap_en),    32'(k < total));
      chk("run_busy",      32'(busy),      32'(k < total));
      chk("run_EN",        32'(EN),        32'(k >= p && k < total));
      chk("run_done",      32'(done),      32'(k >= total));
      chk("run_triggered", 32'(triggered), 32'(k >= s + 2));
      chk("run_cap_addr",  32'(cap_addr),  32'(ca));
      chk("run_wEN",       32'(wEN),       32'(0));
      if (k >= total) chk("run_trig_addr", 32'(trig_addr), 32'(s % (1 << DW)));
      if (k < p)      ResTri = NC'($urandom);
      else if (k < s) ResTri = nonff();
      else            ResTri = '1;
      tick();
    end
    ResTri = '0;
  endtask

  initial begin
    int p, q, s, a;
    RSTn = 1'b0; cfg_wr = 1'b0; cfg_clr = 1'b0; arm = 1'b0; abort = 1'b0;
    cfg_addr = '0; cfg_data = '0; pre_cnt = '0; post_cnt = '0; ResTri = '0;
    last_cmd = '0;
    #3;
    chk_reset("rst");
    RSTn = 1'b1;
    tick(); tick();
    chk_reset("idle");

    // Directed channel write, then an out-of-range address.
    cfg_addr = 8'd3; cfg_data = {1'b1, 1'b0, CMD_POS}; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    chk("wr3_wEN",  32'(wEN),  32'h08);
    chk("wr3_wCMD", 32'(wCMD), 32'h9);
    last_cmd = 4'h9;
    tick();
    chk("wr3_wEN_off", 32'(wEN), 32'h00);
    cfg_addr = 8'd9; cfg_data = CMD_EN | {2'b00, CMD_HIGH}; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    chk("wr9_wEN",  32'(wEN),  32'h00);
    chk("wr9_wCMD", 32'(wCMD), 32'(last_cmd));

    // Clear alone pulses SetInit; clear with write does not.
    cfg_clr = 1'b1;
    tick();
    cfg_clr = 1'b0;
    chk("clr_SetInit", 32'(SetInit), 32'(1));
    tick();
    chk("clr_SetInit_off", 32'(SetInit), 32'(0));
    cfg_clr = 1'b1; cfg_wr = 1'b1; cfg_addr = 8'd5; cfg_data = {2'b00, CMD_NEG};
    tick();
    cfg_clr = 1'b0; cfg_wr = 1'b0;
    last_cmd = {2'b00, CMD_NEG};
    chk("clrwr_SetInit", 32'(SetInit), 32'(0));
    chk("clrwr_wEN",     32'(wEN),     32'h20);
    tick();

    // Random channel writes.
    for (int i = 0; i < 10; i++) begin
      a = int'($urandom_range(0, 11));
      cfg_addr = 8'(a); cfg_data = 4'($urandom); cfg_wr = 1'b1;
      cfg_clr = 1'($urandom_range(0, 1));
      if (i == 0) cfg_data = CMD_EN | {2'b00, CMD_LOW};
      tick();
      cfg_wr = 1'b0; cfg_clr = 1'b0;
      if (a < NC) last_cmd = cfg_data;
      chk("rnd_wEN",     32'(wEN),     (a < NC) ? (32'd1 << a) : 32'd0);
      chk("rnd_wCMD",    32'(wCMD),    32'(last_cmd));
      chk("rnd_SetInit", 32'(SetInit), 32'(0));
      tick();
      chk("rnd_wEN_off", 32'(wEN), 32'(0));
    end

    // Runs: nominal, zero pre/post, random, address wrap.
    do_run(4, 6, 10);
    do_run(0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      p = int'($urandom_range(0, 12));
      q = int'($urandom_range(0, 12));
      s = p + int'($urandom_range(0, 8));
      do_run(p, q, s);
    end
    do_run(1020, 3, 1026);

    // Abort from DONE, then abort in IDLE.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abdone_done",      32'(done),      32'(0));
    chk("abdone_triggered", 32'(triggered), 32'(0));
    chk("abdone_busy",      32'(busy),      32'(0));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abidle_busy",   32'(busy),   32'(0));
    chk("abidle_cap_en", 32'(cap_en), 32'(0));

    // Abort coinciding with hit_q; config and arm while busy are ignored.
    p = int'($urandom_range(2, 6));
    s = p + int'($urandom_range(0, 4));
    pre_cnt = DW'(p); post_cnt = DW'(5); arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k <= s + 1; k++) begin
      if (k == 1) begin
        chk("busywr_wEN",  32'(wEN),  32'(0));
        chk("busywr_wCMD", 32'(wCMD), 32'(last_cmd));
      end
      if (k == 2) chk("busyclr_SetInit", 32'(SetInit), 32'(0));
      cfg_wr  = (k == 0);
      cfg_clr = (k == 1);
      arm     = (k == 1);
      cfg_addr = 8'd2; cfg_data = 4'hB;
      if (k == s + 1) begin
        chk("prehit_busy",      32'(busy),      32'(1));
        chk("prehit_triggered", 32'(triggered), 32'(0));
        abort = 1'b1;
      end
      ResTri = (k < s) ? nonff() : '1;
      tick();
    end
    abort = 1'b0; ResTri = '0; cfg_wr = 1'b0; cfg_clr = 1'b0; arm = 1'b0;
    chk("abhit_busy",      32'(busy),      32'(0));
    chk("abhit_cap_en",    32'(cap_en),    32'(0));
    chk("abhit_EN",        32'(EN),        32'(0));
    chk("abhit_triggered", 32'(triggered), 32'(0));
    chk("abhit_done",      32'(done),      32'(0));
    chk("abhit_cap_addr",  32'(cap_addr),  32'(s + 2));
    tick(); tick();
    chk("abhit_hold_busy",     32'(busy),     32'(0));
    chk("abhit_hold_cap_addr", 32'(cap_addr), 32'(s + 2));

    // Asynchronous reset in the middle of POST.
    pre_cnt = DW'(2); post_cnt = DW'(20); arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ResTri = (k >= 3) ? '1 : '0;
      tick();
    end
    chk("post_busy",      32'(busy),      32'(1));
    chk("post_EN",        32'(EN),        32'(1));
    chk("post_triggered", 32'(triggered), 32'(1));
    #2 RSTn = 1'b0;
    #1;
    chk_reset("midrst");
    last_cmd = '0;
    ResTri = '0;
    tick();
    RSTn = 1'b1;
    tick(); tick(); tick();
    chk_reset("postrst");

    p = int'($urandom_range(0, 8));
    q = int'($urandom_range(0, 8));
    do_run(p, q, p + int'($urandom_range(0, 5)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trig_ctrl.md
TRIG_CTRL -- requirements
Module: trig_ctrl

Interface
REQ-001 Parameter N_CH, default 8: number of trig channels controlled.
REQ-002 Parameter DEPTH_W, default 10: width of the sample counters and the capture address.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset. Ports:
- CLK  in  1  rising-edge clock.
- RSTn  in  1  asynchronous active-low reset.
- cfg_wr  in  1  single-cycle channel-config write strobe.
- cfg_addr  in  8  target channel index.
- cfg_data  in  4  channel command: bit3 enable; bits1:0 = 00 low, 11 high, 01 pos, 10 neg.
- cfg_clr  in  1  clears all channel commands.
- arm  in  1  starts capture.
- abort  in  1  stops capture.
- pre_cnt  in  DEPTH_W  number of pre-trigger samples.
- post_cnt  in  DEPTH_W  number of post-trigger samples.
- ResTri  in  N_CH  per-channel match outputs.
- wCMD  out  4  command bus to the channels.
- wEN  out  N_CH  one-hot channel write enables.
- SetInit  out  1  clear pulse to all channels.
- EN  out  1  channel enable.
- cap_en  out  1  sample-memory write enable.
- cap_addr  out  DEPTH_W  sample write address.
- trig_addr  out  DEPTH_W  cap_addr of the trigger sample.
- triggered  out  1  trigger taken this run.
- busy  out  1  run in progress.
- done  out  1  run complete.

Function
REQ-004 The block SHALL implement the states IDLE, PRE, WAIT, POST and DONE.
REQ-005 Config writes SHALL be accepted only in IDLE or DONE, and ignored in all other states.
- Accepted write: wCMD<=cfg_data and wEN[cfg_addr]<=1 for exactly one cycle, on the cycle after cfg_wr.
- cfg_addr>=N_CH SHALL be ignored.
REQ-006 cfg_clr accepted in IDLE or DONE SHALL pulse SetInit for one cycle.
- If cfg_clr and cfg_wr occur together, cfg_wr wins and SetInit stays 0.
REQ-007 In IDLE or DONE, arm SHALL perform all of the following:
- latch pre_cnt and post_cnt;
- clear cap_addr, triggered and done;
- move to PRE, or to WAIT if pre_cnt==0.
REQ-008 arm SHALL be ignored in PRE, WAIT and POST.
REQ-009 cap_en SHALL be 1 in PRE, WAIT and POST, and 0 otherwise.
- cap_addr SHALL increment by 1 every cycle cap_en==1.
- cap_addr SHALL wrap from 2^DEPTH_W-1 to 0.
REQ-010 PRE SHALL last exactly the latched pre_cnt cycles, with EN=0, then move to WAIT.
REQ-011 In WAIT, EN SHALL be 1.
- hit_q SHALL be registered as (state==WAIT)&(&ResTri).
- When hit_q==1: latch trig_addr<=cap_addr-1, set triggered=1, move to POST (or to DONE if the latched post_cnt==0).
REQ-012 POST SHALL last exactly the latched post_cnt cycles, with EN=1, then move to DONE.
REQ-013 In DONE: EN=0, cap_en=0, done=1.
- done, triggered and trig_addr SHALL hold until the next accepted arm, abort, or reset.
REQ-014 abort in PRE, WAIT or POST SHALL move to IDLE on the next edge.
- On that transition: cap_en=0, EN=0, triggered=0.
- abort SHALL win over a simultaneous hit_q or counter expiry.
- abort in IDLE has no effect; abort in DONE moves to IDLE and clears done.
REQ-015 busy SHALL equal (state is PRE, WAIT or POST).
REQ-016 All outputs SHALL be registered.

Reset
REQ-017 RSTn=0 SHALL immediately force the following, including mid-run:
- state=IDLE;
- wEN=0, SetInit=0, EN=0, cap_en=0, triggered=0, done=0, busy=0;
- wCMD=0, cap_addr=0, trig_addr=0, hit_q=0, counters=0.
REQ-018 Reset SHALL NOT pulse SetInit.
- Software issues cfg_clr after reset.

Structure
REQ-019 The package trig_ctrl_pkg SHALL hold:
- the state enumeration;
- the command field constants (bit3 enable; codes 00, 11, 01, 10);
- default N_CH and DEPTH_W.
REQ-020 One sub-module, trig_cnt, SHALL be used for PRE and POST: a loadable DEPTH_W down-counter with a zero flag, instantiated once.

Verification
REQ-021 In IDLE, cfg_wr with addr=3, data=4'b1001 -> one cycle later wEN=8'h08, wCMD=4'h9 for one cycle. Repeat with addr=9 -> wEN stays 0.
REQ-022 arm with pre_cnt=4, post_cnt=6, ResTri forced 8'hFF from cycle 10 -> the bench checks:
- PRE lasts 4 cycles;
- triggered rises 2 cycles after ResTri (hit_q latency);
- DONE after 6 POST cycles;
- cap_en high for 4 + WAIT + 6 cycles;
- trig_addr equals the address of the hit cycle.
REQ-023 pre_cnt=0, post_cnt=0, ResTri=8'hFF -> PRE skipped; the run reaches DONE with cap_addr=2.
REQ-024 Start cap_addr at 1020 with DEPTH_W=10 -> cap_addr wraps 1023 -> 0 with no gap.
REQ-025 abort asserted in the same cycle as hit_q -> IDLE, triggered=0. cfg_wr while busy -> wEN stays 0.
REQ-026 RSTn low mid-POST -> all outputs reach their reset values without waiting for a clock edge. After release, the block sits in IDLE until arm.
